// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU op codes, pipeline NOP codes,
// exception codes and the multiply/divide FSM state type.
package ex_stage_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_NOP  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADDS = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADDU = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUBS = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUBU = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHRL = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHLL = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MUL  = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_OP_DIVU = 4'd11;
  localparam logic [ALU_OP_W-1:0] ALU_OP_REMU = 4'd12;

  localparam logic [1:0] MEM_OP_NOP  = 2'd0;
  localparam logic [1:0] CTRL_OP_NOP = 2'd0;

  localparam logic [2:0] ISA_EXP_NONE     = 3'h0;
  localparam logic [2:0] ISA_EXP_OVERFLOW = 3'h3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_md_op(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Single-cycle ALU of the execute stage; multiply/divide codes yield 0 here.
module ex_stage_alu
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   in_0,
  input  logic [DATA_W-1:0]   in_1,
  output logic [DATA_W-1:0]   out,
  output logic                overflow
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] sum_s;
  logic signed [DATA_W-1:0] diff_s;

  assign a_s    = $signed(in_0);
  assign b_s    = $signed(in_1);
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;

  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (op)
      ALU_OP_AND:  out = in_0 & in_1;
      ALU_OP_OR:   out = in_0 | in_1;
      ALU_OP_XOR:  out = in_0 ^ in_1;
      ALU_OP_ADDS: begin
        out      = sum_s;
        overflow = (a_s[DATA_W-1] == b_s[DATA_W-1]) && (sum_s[DATA_W-1] != a_s[DATA_W-1]);
      end
      ALU_OP_ADDU: out = sum_s;
      ALU_OP_SUBS: begin
        out      = diff_s;
        overflow = (a_s[DATA_W-1] != b_s[DATA_W-1]) && (diff_s[DATA_W-1] != a_s[DATA_W-1]);
      end
      ALU_OP_SUBU: out = diff_s;
      ALU_OP_SHRL: out = in_0 >> in_1[4:0];
      ALU_OP_SHLL: out = in_0 << in_1[4:0];
      default:     out = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage_ex_reg.sv
// EX/MEM pipeline register: hold on stall, bubble on flush, squash writeback on overflow.
module ex_stage_ex_reg
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              id_en,
  input  logic              id_br_flag,
  input  logic [1:0]        id_mem_op,
  input  logic [DATA_W-1:0] id_mem_wr_data,
  input  logic [1:0]        id_ctrl_op,
  input  logic [4:0]        id_dst_addr,
  input  logic              id_gpr_we_,
  input  logic [2:0]        id_exp_code,
  input  logic              overflow,
  input  logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] ex_pc,
  output logic              ex_en,
  output logic              ex_br_flag,
  output logic [1:0]        ex_mem_op,
  output logic [DATA_W-1:0] ex_mem_wr_data,
  output logic [1:0]        ex_ctrl_op,
  output logic [4:0]        ex_dst_addr,
  output logic              ex_gpr_we_,
  output logic [2:0]        ex_exp_code,
  output logic [DATA_W-1:0] ex_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || (!stall && flush)) begin
      ex_pc          <= '0;
      ex_en          <= 1'b0;
      ex_br_flag     <= 1'b0;
      ex_mem_op      <= MEM_OP_NOP;
      ex_mem_wr_data <= '0;
      ex_ctrl_op     <= CTRL_OP_NOP;
      ex_dst_addr    <= '0;
      ex_gpr_we_     <= 1'b1;
      ex_exp_code    <= ISA_EXP_NONE;
      ex_out         <= '0;
    end else if (!stall) begin
      ex_pc          <= id_pc;
      ex_en          <= id_en;
      ex_br_flag     <= id_br_flag;
      ex_mem_wr_data <= id_mem_wr_data;
      ex_dst_addr    <= id_dst_addr;
      ex_out         <= result;
      // An overflowing instruction reaches MEM only to raise its exception.
      ex_mem_op      <= overflow ? MEM_OP_NOP       : id_mem_op;
      ex_ctrl_op     <= overflow ? CTRL_OP_NOP      : id_ctrl_op;
      ex_gpr_we_     <= overflow ? 1'b1             : id_gpr_we_;
      ex_exp_code    <= overflow ? ISA_EXP_OVERFLOW : id_exp_code;
    end
  end

endmodule

// File: rtl/ex_stage_md_unit.sv
// Iterative multiply (shift-add) and unsigned divide (restoring), one bit per cycle.
module ex_stage_md_unit
  import ex_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MD_STEPS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                stall,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   in_0,
  input  logic [DATA_W-1:0]   in_1,
  output logic [DATA_W-1:0]   result,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = $clog2(MD_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_STEPS - 1);

  md_state_e           state;
  logic [CNT_W-1:0]    cnt;
  logic [ALU_OP_W-1:0] op_r;
  // acc: product / partial remainder; x: multiplicand / divisor; y: multiplier / dividend->quotient
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   x;
  logic [DATA_W-1:0]   y;
  logic [DATA_W:0]     trial;

  assign trial = {acc, y[DATA_W-1]} - {1'b0, x};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      op_r  <= ALU_OP_NOP;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          state <= MD_RUN;
          cnt   <= '0;
          op_r  <= op;
        end
        MD_RUN: begin
          if (abort)                 state <= MD_IDLE;
          else if (cnt == CNT_LAST)  state <= MD_DONE;
          else                       cnt   <= cnt + 1'b1;
        end
        MD_DONE: if (abort || !stall) state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  // Datapath carries no reset; its contents only matter while state is RUN/DONE.
  always_ff @(posedge clk) begin
    if (state == MD_IDLE && start) begin
      acc <= '0;
      if (op == ALU_OP_MUL) begin
        x <= in_0;
        y <= in_1;
      end else begin
        x <= in_1;
        y <= in_0;
      end
    end else if (state == MD_RUN) begin
      if (op_r == ALU_OP_MUL) begin
        if (y[0]) acc <= acc + x;
        x <= x << 1;
        y <= y >> 1;
      end else if (!trial[DATA_W]) begin
        acc <= trial[DATA_W-1:0];
        y   <= {y[DATA_W-2:0], 1'b1};
      end else begin
        acc <= {acc[DATA_W-2:0], y[DATA_W-1]};
        y   <= {y[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign done   = (state == MD_DONE);
  assign busy   = reset && ((state == MD_RUN) || ((state == MD_IDLE) && start));
  assign result = !done                ? '0 :
                  (op_r == ALU_OP_DIVU) ? y  : acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, iterative multiply/divide and the EX/MEM pipeline register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 30,
  parameter int MD_STEPS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                int_detect,
  output logic                busy,
  output logic [DATA_W-1:0]   fwd_data,
  input  logic [ADDR_W-1:0]   id_pc,
  input  logic                id_en,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]   id_alu_in_0,
  input  logic [DATA_W-1:0]   id_alu_in_1,
  input  logic                id_br_flag,
  input  logic [1:0]          id_mem_op,
  input  logic [DATA_W-1:0]   id_mem_wr_data,
  input  logic [1:0]          id_ctrl_op,
  input  logic [4:0]          id_dst_addr,
  input  logic                id_gpr_we_,
  input  logic [2:0]          id_exp_code,
  output logic [ADDR_W-1:0]   ex_pc,
  output logic                ex_en,
  output logic                ex_br_flag,
  output logic [1:0]          ex_mem_op,
  output logic [DATA_W-1:0]   ex_mem_wr_data,
  output logic [1:0]          ex_ctrl_op,
  output logic [4:0]          ex_dst_addr,
  output logic                ex_gpr_we_,
  output logic [2:0]          ex_exp_code,
  output logic [DATA_W-1:0]   ex_out
);

  logic              kill;
  logic              md_op;
  logic              md_start;
  logic              md_done;
  logic [DATA_W-1:0] md_result;
  logic [DATA_W-1:0] alu_out;
  logic              alu_ovf;

  assign kill     = flush || int_detect;
  assign md_op    = is_md_op(id_alu_op);
  assign md_start = id_en && md_op && !kill;
  assign fwd_data = md_op ? md_result : alu_out;

  ex_stage_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (id_alu_op),
    .in_0     (id_alu_in_0),
    .in_1     (id_alu_in_1),
    .out      (alu_out),
    .overflow (alu_ovf)
  );

  ex_stage_md_unit #(.DATA_W(DATA_W), .MD_STEPS(MD_STEPS)) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .abort  (kill),
    .stall  (stall),
    .op     (id_alu_op),
    .in_0   (id_alu_in_0),
    .in_1   (id_alu_in_1),
    .result (md_result),
    .busy   (busy),
    .done   (md_done)
  );

  ex_stage_ex_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ex_reg (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (kill),
    .id_pc          (id_pc),
    .id_en          (id_en),
    .id_br_flag     (id_br_flag),
    .id_mem_op      (id_mem_op),
    .id_mem_wr_data (id_mem_wr_data),
    .id_ctrl_op     (id_ctrl_op),
    .id_dst_addr    (id_dst_addr),
    .id_gpr_we_     (id_gpr_we_),
    .id_exp_code    (id_exp_code),
    .overflow       (alu_ovf),
    .result         (fwd_data),
    .ex_pc          (ex_pc),
    .ex_en          (ex_en),
    .ex_br_flag     (ex_br_flag),
    .ex_mem_op      (ex_mem_op),
    .ex_mem_wr_data (ex_mem_wr_data),
    .ex_ctrl_op     (ex_ctrl_op),
    .ex_dst_addr    (ex_dst_addr),
    .ex_gpr_we_     (ex_gpr_we_),
    .ex_exp_code    (ex_exp_code),
    .ex_out         (ex_out)
  );

endmodule
